// File: rtl/bram_arb_pkg.sv
// Shared types and default constants for the block-RAM arbiter and its RAM.
package bram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sp_bram.sv
// Single-port synchronous RAM with registered read; a write returns the old word.
module sp_bram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port RAM between fetch (read-only) and load/store ports,
// clearing the RAM after reset and guarding fetch against starvation.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v >= SC_MAX) ? SC_MAX : v + 1'b1;
    endfunction

    state_t            state_p0, state_next;
    logic [ADDR_W-1:0] init_cnt_p0;
    logic [SC_W-1:0]   starve_cnt_p0;
    owner_t            owner_p1, owner_next;
    logic [DATA_W-1:0] i_rdata_p1, d_rdata_p1;

    logic              run;
    logic              force_i;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata_p1;

    // Stage 0: arbitration and memory command, combinational from requests
    assign run     = (state_p0 == ST_RUN) && !reset;
    assign force_i = i_req && (starve_cnt_p0 == SC_MAX);
    assign d_gnt   = run && d_req && !force_i;
    assign i_gnt   = run && i_req && !d_gnt;
    assign ready   = (state_p0 == ST_RUN);

    always_comb begin
        state_next = state_p0;
        owner_next = OWN_NONE;
        mem_we     = 1'b0;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
        if (state_p0 == ST_INIT) begin
            mem_we    = !reset;
            mem_addr  = init_cnt_p0;
            mem_wdata = INIT_VALUE;
            if (init_cnt_p0 == {ADDR_W{1'b1}}) begin
                state_next = ST_RUN;
            end
        end else if (i_gnt) begin
            mem_addr   = i_addr;
            owner_next = OWN_I;
        end else if (d_gnt) begin
            mem_we     = d_we;
            owner_next = d_we ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0      <= ST_INIT;
            init_cnt_p0   <= '0;
            starve_cnt_p0 <= '0;
            owner_p1      <= OWN_NONE;
            i_rdata_p1    <= '0;
            d_rdata_p1    <= '0;
        end else begin
            state_p0 <= state_next;
            owner_p1 <= owner_next;
            if (state_p0 == ST_INIT) begin
                init_cnt_p0 <= init_cnt_p0 + 1'b1;
            end
            if (run && i_req && !i_gnt) begin
                starve_cnt_p0 <= sat_inc(starve_cnt_p0);
            end else begin
                starve_cnt_p0 <= '0;
            end
            if (i_rvalid) begin
                i_rdata_p1 <= mem_rdata_p1;
            end
            if (d_rvalid) begin
                d_rdata_p1 <= mem_rdata_p1;
            end
        end
    end

    sp_bram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clock(clock),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata_p1)
    );

    // Stage 1: route RAM output to the port that issued the read; hold otherwise
    assign i_rvalid = (owner_p1 == OWN_I) && !reset;
    assign d_rvalid = (owner_p1 == OWN_D) && !reset;
    assign i_rdata  = i_rvalid ? mem_rdata_p1 : i_rdata_p1;
    assign d_rdata  = d_rvalid ? mem_rdata_p1 : d_rdata_p1;

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port arbiter and sequencer for the single-port 256×32 block RAM behind the Hivek core. It shares one memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write). After reset it clears the memory to a known value before accepting traffic. Data accesses take priority, and a starvation guard guarantees forward progress for fetch.

## Interface
Parameters:
- ADDR_W, 8, address width; memory depth 2^ADDR_W words
- DATA_W, 32, word width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (≥1)
- INIT_VALUE, 0, word written to every location during initialisation

Ports:
- Clock and reset: clock in, reset in; reset is synchronous, active-high.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once initialisation is complete
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request accepted this cycle
- i_rdata  out  DATA_W  fetch read data
- i_rvalid  out  1  i_rdata valid
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rdata  out  DATA_W  data read data
- d_rvalid  out  1  d_rdata valid (reads only)

## Operation
- FSM states:
  - ST_INIT: entered on reset. An ADDR_W-bit init counter writes INIT_VALUE to address = counter, one word per cycle. When the counter reaches 2^ADDR_W−1, that word is written and the FSM moves to ST_RUN.
  - ST_RUN: normal arbitration; no exit except reset.
- Grant rules in ST_RUN:
  - Grants are combinational from req in the same cycle.
  - At most one grant per cycle.
  - Default priority: d_req beats i_req.
  - Starvation guard: when starve_cnt == STARVE_LIMIT and i_req=1, fetch wins over data.
- starve_cnt:
  - increments while i_req && !i_gnt in ST_RUN (saturating at STARVE_LIMIT);
  - clears on i_gnt, on !i_req, and on reset.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - It may drop or change them in the cycle after gnt.
  - Back-to-back grants to the same port are allowed.
- Owner register (OWN_NONE / OWN_I / OWN_D) records which port's read was issued. It routes the memory output on the following cycle.
- Read data:
  - x_rdata updates only together with x_rvalid.
  - x_rdata holds its last value otherwise.
- Writes: a granted d_we=1 access writes memory and produces no d_rvalid.
- Write-then-read to the same address in consecutive grants returns the new data.
- In ST_INIT: i_gnt=d_gnt=0 regardless of requests.

## Timing
- Reset values: ready=0, i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, owner=OWN_NONE, starve_cnt=0, init counter=0.
- Init length: with reset asserted in cycle 0 and deasserted in cycle 1, addresses 0..2^ADDR_W−1 are written in cycles 1..2^ADDR_W. ready rises at cycle 2^ADDR_W+1, which is the first cycle a grant can occur.
- Read latency: gnt in cycle N → rvalid high for exactly one cycle in N+1, with the addressed word.
- Throughput: one access per cycle total.
- Reset mid-init: the init counter restarts at 0 and the full clear is repeated.
- Reset in ST_RUN: any rvalid due in the next cycle is suppressed, and the FSM returns to ST_INIT.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: d_gnt=1, i_gnt=0, starve_cnt+1.

## Structure
- Package bram_arb_pkg: state enum (ST_INIT, ST_RUN), owner enum (OWN_NONE, OWN_I, OWN_D), default parameter constants.
- Sub-module sp_bram: single-port synchronous RAM, 2^ADDR_W×DATA_W.
  - Ports: clock, we, addr, wdata, rdata.
  - Registered read, read-old-data on write.
  - No reset of contents; clearing is done by the arbiter's init sequence.
- The arbiter contains the FSM, init counter, priority/starvation logic, owner register and output data registers.

## Test plan
- Init: reset for 2 cycles, then read addresses 0, 4, 255 via d port after ready → each returns INIT_VALUE. ready rises exactly 256 cycles after reset release, and no gnt occurs before it.
- Single fetch: d write 0xDEADBEEF to addr 8, then i read addr 8 → i_gnt same cycle as i_req, i_rvalid next cycle with 0xDEADBEEF, d_rvalid stays 0.
- Contention: i_req and d_req (read addr 3) both high → d_gnt=1 and i_gnt=0; next cycle d_req low → i_gnt=1. Each rvalid appears on its own port only.
- Starvation: STARVE_LIMIT=4, d_req held high continuously, i_req high → i_gnt=0 for 4 cycles, i_gnt=1 on the 5th cycle (d_gnt=0 that cycle), then d wins again.
- Back-to-back write/read: d write 0x12345678 to addr 200, then d read addr 200 in the next cycle → d_rdata=0x12345678 one cycle after the read grant.
- Reset mid-init: assert reset at init counter 100 → ready stays 0 and becomes 1 exactly 256 cycles after the second reset release.
